// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: CDB owner codes and divider FSM encodings shared by the issue scheduler.
package issue_scheduler_pkg;
  typedef enum logic [2:0] {
    CDB_NONE  = 3'd0,
    CDB_INT   = 3'd1,
    CDB_MULT  = 3'd2,
    CDB_DIV   = 3'd3,
    CDB_LDBUF = 3'd4
  } cdb_owner_e;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/cdb_slot_shreg.sv
// cdb_slot_shreg: CDB reservation shift register with a next-cycle write and a far (mult) write.
// The topmost reservation is always empty after a shift, so only DEPTH entries are stored.
module cdb_slot_shreg
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       near_we,
  input  cdb_owner_e near_code,
  input  logic       far_we,
  input  cdb_owner_e far_code,
  output cdb_owner_e slot0,
  output cdb_owner_e slot1
);
  logic [DEPTH-1:0][2:0] slot, slot_nxt;
  always_comb begin
    slot_nxt = {3'b000, slot[DEPTH-1:1]};
    if (near_we) slot_nxt[0] = near_code;
    if (far_we) slot_nxt[DEPTH-1] = far_code;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) slot <= '0;
    else slot <= slot_nxt;
  assign slot0 = cdb_owner_e'(slot[0]);
  assign slot1 = cdb_owner_e'(slot[1]);
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: grants int/mult/div/ld_buf issue against CDB reservations so one unit drives the CDB per cycle.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int MULT_LAT    = 4,
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_int,
  input  logic       ready_mult,
  input  logic       ready_div,
  input  logic       ready_ld_buf,
  input  logic       div_done,
  output logic       issue_int,
  output logic       issue_mult,
  output logic       issue_div,
  output logic       issue_ld_buf,
  output logic       div_ack,
  output logic [2:0] cdb_sel,
  output logic       cdb_valid,
  output logic       div_busy
);
  div_state_e state, state_nxt;
  cdb_owner_e slot0, slot1, near_code;
  logic last_ld, open, int_wins;
  // A finished divide owns the free slot ahead of int/ld_buf.
  assign open         = reset && slot1 == CDB_NONE && state != DIV_DONE;
  assign int_wins     = ROUND_ROBIN == 0 || !ready_ld_buf || last_ld;
  assign issue_int    = open && ready_int && int_wins;
  assign issue_ld_buf = open && ready_ld_buf && !issue_int;
  assign issue_mult   = reset && ready_mult;
  assign near_code    = div_ack ? CDB_DIV : issue_int ? CDB_INT : CDB_LDBUF;
  assign cdb_sel      = slot0;
  assign cdb_valid    = slot0 != CDB_NONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= DIV_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == DIV_IDLE ? (issue_div ? DIV_BUSY : DIV_IDLE) :
                state == DIV_BUSY ? (div_done ? DIV_DONE : DIV_BUSY) :
                state == DIV_DONE ? (div_ack ? DIV_IDLE : DIV_DONE) : DIV_IDLE;
  always_comb begin
    issue_div = reset && state == DIV_IDLE && ready_div;
    div_ack   = reset && state == DIV_DONE && slot1 == CDB_NONE;
    div_busy  = state != DIV_IDLE;
  end
  // Reset value favours int on the first contested cycle.
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_ld <= 1'b1;
    else last_ld <= issue_int ? 1'b0 : issue_ld_buf ? 1'b1 : last_ld;
  cdb_slot_shreg #(.DEPTH(MULT_LAT)) u_slots (
    .clk      (clk),
    .reset    (reset),
    .near_we  (div_ack || issue_int || issue_ld_buf),
    .near_code(near_code),
    .far_we   (issue_mult),
    .far_code (CDB_MULT),
    .slot0    (slot0),
    .slot1    (slot1)
  );
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: per-cycle vector table for grants plus a CDB-owner scoreboard, then a mid-flight reset sequence.
module tb_issue_scheduler;
  localparam int MULT = 4;
  logic clk = 0, reset = 0;
  logic ri = 0, rm = 0, rd = 0, rl = 0, dd = 0;
  logic ii, im, id, il, ack, cv, busy;
  logic [2:0] cs;
  logic f_ii, f_im, f_id, f_il, f_ack, f_cv, f_busy;
  logic [2:0] f_cs;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  issue_scheduler #(.MULT_LAT(MULT), .ROUND_ROBIN(1)) dut (
    .clk(clk), .reset(reset), .ready_int(ri), .ready_mult(rm), .ready_div(rd),
    .ready_ld_buf(rl), .div_done(dd), .issue_int(ii), .issue_mult(im), .issue_div(id),
    .issue_ld_buf(il), .div_ack(ack), .cdb_sel(cs), .cdb_valid(cv), .div_busy(busy));
  issue_scheduler #(.MULT_LAT(MULT), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset(reset), .ready_int(ri), .ready_mult(rm), .ready_div(rd),
    .ready_ld_buf(rl), .div_done(dd), .issue_int(f_ii), .issue_mult(f_im), .issue_div(f_id),
    .issue_ld_buf(f_il), .div_ack(f_ack), .cdb_sel(f_cs), .cdb_valid(f_cv), .div_busy(f_busy));
  typedef struct packed {
    logic [4:0] in;
    logic [5:0] ex;
  } vec_t;
  typedef struct {
    int cyc;
    logic [2:0] code;
  } sb_t;
  vec_t vt[$];
  sb_t sb[$];
  task automatic chk(input string nm, input int c, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
    end
  endtask
  task automatic add(input int n, input logic [4:0] i, input logic [5:0] e);
    vec_t v;
    v.in = i;
    v.ex = e;
    for (int k = 0; k < n; k++) vt.push_back(v);
  endtask
  initial begin
    logic [2:0] exp_cdb;
    // inputs {ri,rm,rd,rl,dd}; expected {issue_int,issue_mult,issue_div,issue_ld_buf,div_ack,div_busy}
    add(1, 5'b10010, 6'b100000);
    add(1, 5'b10010, 6'b000100);
    add(1, 5'b10010, 6'b100000);
    add(1, 5'b10010, 6'b000100);
    add(1, 5'b00000, 6'b000000);
    add(1, 5'b10000, 6'b100000);
    add(2, 5'b00000, 6'b000000);
    add(1, 5'b01000, 6'b010000);
    add(2, 5'b00000, 6'b000000);
    add(1, 5'b10000, 6'b000000);
    add(1, 5'b10000, 6'b100000);
    add(1, 5'b00000, 6'b000000);
    add(3, 5'b01000, 6'b010000);
    add(3, 5'b11000, 6'b010000);
    add(3, 5'b10000, 6'b000000);
    add(1, 5'b10000, 6'b100000);
    add(2, 5'b00000, 6'b000000);
    add(1, 5'b00100, 6'b001000);
    add(1, 5'b00000, 6'b000001);
    add(1, 5'b00100, 6'b000001);
    add(7, 5'b00000, 6'b000001);
    add(1, 5'b00001, 6'b000001);
    add(1, 5'b10000, 6'b000011);
    add(1, 5'b10000, 6'b100000);
    add(1, 5'b00001, 6'b000000);
    add(1, 5'b00000, 6'b000000);
    add(1, 5'b11100, 6'b111000);
    add(4, 5'b00000, 6'b000001);
    ri = 1; rm = 1; rd = 1; rl = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grants", -1, {4'b0, ii, im, id, il}, 8'h00);
    chk("reset_cdb", -1, {4'b0, cs, cv}, 8'h00);
    chk("reset_busy_ack", -1, {6'b0, busy, ack}, 8'h00);
    {ri, rm, rd, rl, dd} = '0;
    reset = 1;
    for (int i = 0; i < vt.size(); i++) begin
      {ri, rm, rd, rl, dd} = vt[i].in;
      if (vt[i].ex[5]) sb.push_back('{i + 1, 3'd1});
      if (vt[i].ex[2]) sb.push_back('{i + 1, 3'd4});
      if (vt[i].ex[1]) sb.push_back('{i + 1, 3'd3});
      if (vt[i].ex[4]) sb.push_back('{i + MULT, 3'd2});
      @(negedge clk);
      chk("grants", i, {4'b0, ii, im, id, il}, {4'b0, vt[i].ex[5:2]});
      chk("div_ack", i, {7'b0, ack}, {7'b0, vt[i].ex[1]});
      chk("div_busy", i, {7'b0, busy}, {7'b0, vt[i].ex[0]});
      exp_cdb = 3'd0;
      for (int k = 0; k < sb.size(); k++)
        if (sb[k].cyc == i) begin
          exp_cdb = sb[k].code;
          sb.delete(k);
          break;
        end
      chk("cdb_sel", i, {5'b0, cs}, {5'b0, exp_cdb});
      chk("cdb_valid", i, {7'b0, cv}, {7'b0, exp_cdb != 3'd0});
      if (i < 4) chk("fixed_prio_int", i, {7'b0, f_ii}, 8'h01);
      @(posedge clk);
      #1;
    end
    chk("sb_drain", -1, 8'(sb.size()), 8'h00);
    {ri, rm, rd, rl, dd} = 5'b01000;
    @(negedge clk);
    chk("rst_mult_issue", -1, {7'b0, im}, 8'h01);
    @(posedge clk);
    #1;
    {ri, rm, rd, rl, dd} = 5'b10000;
    @(negedge clk);
    chk("rst_int_issue", -1, {7'b0, ii}, 8'h01);
    @(posedge clk);
    #1;
    ri = 0;
    chk("pre_reset_cdb", -1, {4'b0, cs, cv}, {4'b0, 3'd1, 1'b1});
    chk("pre_reset_busy", -1, {7'b0, busy}, 8'h01);
    reset = 0;
    #1;
    chk("async_reset_cdb", -1, {4'b0, cs, cv}, 8'h00);
    chk("async_reset_busy", -1, {7'b0, busy}, 8'h00);
    {ri, rm, rd, rl} = 4'b1111;
    #1;
    chk("reset_low_grants", -1, {4'b0, ii, im, id, il}, 8'h00);
    {ri, rm, rd, rl} = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_reset_cdb", c, {4'b0, cs, cv}, 8'h00);
      chk("post_reset_busy", c, {7'b0, busy}, 8'h00);
      @(posedge clk);
      #1;
    end
    {ri, rl} = 2'b11;
    @(negedge clk);
    chk("post_reset_rr", -1, {6'b0, ii, il}, 8'h02);
    @(posedge clk);
    #1;
    {ri, rl} = 2'b00;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
Decides which execution unit is issued each cycle and which unit owns the common data bus (CDB) in each cycle. It grants the int, mult, div and ld_buf issue queues against a CDB reservation shift register. The issue unit's datapath muxes operands and result drivers using these grants and `cdb_sel`. One CDB write per cycle is guaranteed by construction.

Parameters:
MULT_LAT, 4, multiplier pipeline latency in cycles from issue to CDB drive (legal 2..8)
ROUND_ROBIN, 1, 1 = int/ld_buf share the next-cycle slot round-robin; 0 = int has fixed priority

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ready_int  in  1  int queue has a ready instruction
ready_mult  in  1  mult queue has a ready instruction
ready_div  in  1  div queue has a ready instruction
ready_ld_buf  in  1  load buffer has a ready result
div_done  in  1  divider finished; result held until div_ack
issue_int  out  1  grant to int queue (combinational)
issue_mult  out  1  grant to mult queue (combinational)
issue_div  out  1  grant to div queue, starts the divider (combinational)
issue_ld_buf  out  1  grant to load buffer (combinational)
div_ack  out  1  divider result granted; the divider drives the CDB next cycle (combinational)
cdb_sel  out  3  current CDB owner: 0 none, 1 int, 2 mult, 3 div, 4 ld_buf
cdb_valid  out  1  cdb_sel != 0
div_busy  out  1  divider FSM not IDLE

Behaviour:
- State: `slot[0..MULT_LAT]`, each 3-bit owner code. `slot[0]` is the current CDB owner. Each clock edge: `slot[k] <= slot[k+1]` and `slot[MULT_LAT] <= 0`. Grants made in a cycle overwrite the shifted value.
- `cdb_sel = slot[0]`; `cdb_valid = |slot[0]`. Both are registered-state outputs.
- Next-cycle slot is free when `slot[1] == 0`. Priority for the free slot: div result (div FSM in DONE) > int/ld_buf arbitration. At most one winner; the winner writes code into `slot[0]` at the edge (the shifted position of `slot[1]`).
- int/ld_buf arbitration: with ROUND_ROBIN=1, a 1-bit `last` register. If both request, the one not granted last wins. `last` updates only on an int or ld_buf grant. With ROUND_ROBIN=0, int always wins.
- Mult: `issue_mult = ready_mult`. It is always granted because `slot[MULT_LAT]` is empty after the shift. It writes code 2 into `slot[MULT_LAT-1]` post-shift, so the result is on the CDB MULT_LAT cycles after the grant. Back-to-back mults are allowed every cycle.
- Same cycle: mult, div issue and one slot-1 winner may all be granted together.
- Div FSM:
  - IDLE: `issue_div = ready_div`; on grant go to BUSY.
  - BUSY: `issue_div = 0`; on `div_done` go to DONE.
  - DONE: when the next-cycle slot is free, `div_ack = 1`, write code 3, go to IDLE.
  - A new div can be issued the cycle after `div_ack`.
  - `div_done` is ignored outside BUSY. `div_busy = (state != IDLE)`.
- Latency: int/ld_buf/div result is on the CDB 1 cycle after its grant; mult after MULT_LAT cycles.
- Reset (async, low): all slots 0, FSM IDLE, `last` = ld_buf (so int wins first), `cdb_valid` = 0 immediately. In-flight reservations are discarded. Grants are forced to 0 while reset is low.
- No grant is issued without the corresponding ready. Grants are valid only in the cycle they are asserted; queues must sample them at the rising edge.

Decomposition:
- Shared package: owner codes `CDB_NONE`=0, `CDB_INT`=1, `CDB_MULT`=2, `CDB_DIV`=3, `CDB_LDBUF`=4, and div FSM state encodings (IDLE/BUSY/DONE).
- One sub-module is natural: `cdb_slot_shreg` (parameterised depth, shift plus indexed write, exports `slot[0]` and `slot[1]`). The arbitration and div FSM stay in the top module.

Test Plan:
1. Int alone: after reset, `ready_int`=1 at cycle t only → `issue_int`=1 at t; `cdb_sel`=1, `cdb_valid`=1 at t+1; `cdb_valid`=0 at t+2.
2. Mult collision (MULT_LAT=4): `ready_mult` at t, `ready_int` held from t+3 → `issue_int`=0 at t+3 and `cdb_sel`=2 at t+4; `issue_int`=1 at t+4 and `cdb_sel`=1 at t+5.
3. Round-robin: `ready_int` and `ready_ld_buf` both held 4 cycles → grants int, ld_buf, int, ld_buf; `cdb_sel` sequence 1,4,1,4. With ROUND_ROBIN=0 → int granted all 4 cycles.
4. Divide: `ready_div` at t → `issue_div`=1 and `div_busy`=1 from t+1; `ready_div` again at t+2 → no grant. `div_done` at t+10 with `ready_int`=1 at t+11 → `div_ack`=1 and `issue_int`=0 at t+11; `cdb_sel`=3 at t+12; `div_busy`=0 at t+12.
5. Back-to-back mult: `ready_mult`=1 for 6 cycles from t → `issue_mult` every cycle; `cdb_sel`=2 from t+4 through t+9; int requests are blocked in those slots.
6. Reset mid-flight: mult at t, `reset` low at t+2 → `cdb_valid`=0 immediately. After release no `cdb_sel`=2 appears, and div FSM is IDLE.
